mc_control_fsm: RTL and testbench

Multicycle control unit for the 16-bit processor datapath. Sequences fetch, decode, execute, memory and writeback for each instruction and drives every datapath mux select, register write enable, and ALU operation. This includes the ALU constant-operand selection: constant 2 for PC increment, constant 12 as the LUI shift amount. Sits between the instruction register opcode field and the datapath control inputs; handshakes with memory through `mem_ready`.

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/mc_ctrl_decode.sv | 112 +++++++++++
 rtl/mc_control_fsm.sv | 134 +++++++++++++
 tb/tb_mc_control_fsm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared encodings for the multicycle control unit: FSM
//                states, opcodes, ALU operations and datapath mux codes.
//                Optional macro MC_CTRL_HALT_EN makes opcode 15 a HALT.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_ADDI = 4'd4;
    localparam logic [3:0] c_OP_LW   = 4'd5;
    localparam logic [3:0] c_OP_SW   = 4'd6;
    localparam logic [3:0] c_OP_BEQ  = 4'd7;
    localparam logic [3:0] c_OP_J    = 4'd8;
    localparam logic [3:0] c_OP_LUI  = 4'd9;
    localparam logic [3:0] c_OP_HALT = 4'd15;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_SLL = 3'd4;

    localparam logic [1:0] c_A_PC    = 2'd0;
    localparam logic [1:0] c_A_REGA  = 2'd1;
    localparam logic [1:0] c_A_IMM4  = 2'd2;

    localparam logic [1:0] c_B_REGB  = 2'd0;
    localparam logic [1:0] c_B_TWO   = 2'd1;
    localparam logic [1:0] c_B_IMM8  = 2'd2;
    localparam logic [1:0] c_B_TWELVE = 2'd3;

    localparam logic [1:0] c_PC_ALU    = 2'd0;
    localparam logic [1:0] c_PC_ALUOUT = 2'd1;
    localparam logic [1:0] c_PC_JUMP   = 2'd2;

    // Opcodes 10..14 are never defined; 15 is only defined when HALT is built in.
    function automatic logic f_is_illegal(input logic [3:0] i_op);
`ifdef MC_CTRL_HALT_EN
        return (i_op >= 4'd10) && (i_op <= 4'd14);
`else
        return (i_op >= 4'd10);
`endif
    endfunction

    // R-type instructions occupy opcodes 0..3 and use opcode[1:0] as ALU op.
    function automatic logic f_is_rtype(input logic [3:0] i_op);
        return (i_op[3:2] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_decode
//  Description : Combinational decoder from (state, opcode, mem_ready) to
//                every datapath control output. Optional macro
//                MC_CTRL_HALT_EN enables the halted indication.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [3:0]  i_opcode,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_pc_write_cond,
    output logic        o_ir_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_iord,
    output logic        o_reg_write,
    output logic        o_reg_dst,
    output logic        o_mem_to_reg,
    output logic [1:0]  o_alu_a_sel,
    output logic [1:0]  o_alu_b_sel,
    output logic [2:0]  o_alu_op,
    output logic [1:0]  o_pc_src,
    output logic        o_illegal,
    output logic        o_halted
);

    // Per-state control decode; anything not named for a state stays 0.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_iord          = 1'b0;
        o_reg_write     = 1'b0;
        o_reg_dst       = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_alu_a_sel     = c_A_PC;
        o_alu_b_sel     = c_B_REGB;
        o_alu_op        = c_ALU_ADD;
        o_pc_src        = c_PC_ALU;
        o_illegal       = 1'b0;
        o_halted        = 1'b0;
        case (i_state)
            ST_FETCH: begin
                // PC+2 computed every fetch cycle, committed only when memory answers
                o_mem_read  = 1'b1;
                o_alu_b_sel = c_B_TWO;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target PC + imm8 lands in ALUOut
                o_alu_b_sel = c_B_IMM8;
                o_illegal   = f_is_illegal(i_opcode);
            end
            ST_EXEC: begin
                case (i_opcode)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
                        o_alu_a_sel = c_A_REGA;
                        o_alu_b_sel = c_B_REGB;
                        o_alu_op    = {1'b0, i_opcode[1:0]};
                    end
                    c_OP_ADDI, c_OP_LW, c_OP_SW: begin
                        o_alu_a_sel = c_A_REGA;
                        o_alu_b_sel = c_B_IMM8;
                    end
                    c_OP_BEQ: begin
                        o_alu_a_sel     = c_A_REGA;
                        o_alu_b_sel     = c_B_REGB;
                        o_alu_op        = c_ALU_SUB;
                        o_pc_write_cond = 1'b1;
                        o_pc_src        = c_PC_ALUOUT;
                    end
                    c_OP_J: begin
                        o_pc_write = 1'b1;
                        o_pc_src   = c_PC_JUMP;
                    end
                    c_OP_LUI: begin
                        o_alu_a_sel = c_A_IMM4;
                        o_alu_b_sel = c_B_TWELVE;
                        o_alu_op    = c_ALU_SLL;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                o_iord      = 1'b1;
                o_mem_read  = (i_opcode == c_OP_LW);
                o_mem_write = (i_opcode == c_OP_SW);
            end
            ST_WB: begin
                o_reg_write  = 1'b1;
                o_reg_dst    = f_is_rtype(i_opcode);
                o_mem_to_reg = (i_opcode == c_OP_LW);
            end
            ST_HALT: begin
`ifdef MC_CTRL_HALT_EN
                o_halted = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_fsm
//  Description : Multicycle control unit top: state register and next-state
//                logic; control outputs come from mc_ctrl_decode and are
//                forced low while RST_N is asserted. Optional macro
//                MC_CTRL_HALT_EN routes opcode 15 to the HALT state.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        halted
);

    state_t      r_state;
    state_t      w_next_state;

    logic        w_pc_write, w_pc_write_cond, w_ir_write, w_mem_read, w_mem_write;
    logic        w_iord, w_reg_write, w_reg_dst, w_mem_to_reg, w_illegal, w_halted;
    logic [1:0]  w_alu_a_sel, w_alu_b_sel, w_pc_src;
    logic [2:0]  w_alu_op;

    // The zero flag is consumed by the datapath through pc_write_cond only.
    logic        w_unused_zero;
    assign w_unused_zero = zero;

    // Next-state sequencing of the fetch/decode/execute/memory/writeback cycle
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (f_is_illegal(opcode)) begin
                    w_next_state = ST_FETCH;
`ifdef MC_CTRL_HALT_EN
                end else if (opcode == c_OP_HALT) begin
                    w_next_state = ST_HALT;
`endif
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    c_OP_LW, c_OP_SW:                         w_next_state = ST_MEM;
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
                    c_OP_ADDI, c_OP_LUI:                      w_next_state = ST_WB;
                    default:                                  w_next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!mem_ready)
                    w_next_state = ST_MEM;
                else if (opcode == c_OP_LW)
                    w_next_state = ST_WB;
                else
                    w_next_state = ST_FETCH;
            end
            ST_WB:     w_next_state = ST_FETCH;
            ST_HALT:   w_next_state = ST_HALT;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // State register; reset drops straight back to FETCH mid-instruction
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_state <= ST_FETCH;
        else
            r_state <= w_next_state;
    end

    mc_ctrl_decode u_decode (
        .i_state         (r_state),
        .i_opcode        (opcode),
        .i_mem_ready     (mem_ready),
        .o_pc_write      (w_pc_write),
        .o_pc_write_cond (w_pc_write_cond),
        .o_ir_write      (w_ir_write),
        .o_mem_read      (w_mem_read),
        .o_mem_write     (w_mem_write),
        .o_iord          (w_iord),
        .o_reg_write     (w_reg_write),
        .o_reg_dst       (w_reg_dst),
        .o_mem_to_reg    (w_mem_to_reg),
        .o_alu_a_sel     (w_alu_a_sel),
        .o_alu_b_sel     (w_alu_b_sel),
        .o_alu_op        (w_alu_op),
        .o_pc_src        (w_pc_src),
        .o_illegal       (w_illegal),
        .o_halted        (w_halted)
    );

    // Gate every output with RST_N so no write can slip out during reset
    assign pc_write      = w_pc_write      & RST_N;
    assign pc_write_cond = w_pc_write_cond & RST_N;
    assign ir_write      = w_ir_write      & RST_N;
    assign mem_read      = w_mem_read      & RST_N;
    assign mem_write     = w_mem_write     & RST_N;
    assign iord          = w_iord          & RST_N;
    assign reg_write     = w_reg_write     & RST_N;
    assign reg_dst       = w_reg_dst       & RST_N;
    assign mem_to_reg    = w_mem_to_reg    & RST_N;
    assign alu_a_sel     = w_alu_a_sel     & {2{RST_N}};
    assign alu_b_sel     = w_alu_b_sel     & {2{RST_N}};
    assign alu_op        = w_alu_op        & {3{RST_N}};
    assign pc_src        = w_pc_src        & {2{RST_N}};
    assign illegal       = w_illegal       & RST_N;
    assign halted        = w_halted        & RST_N;
    assign state         = r_state         & {3{RST_N}};

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control_fsm
//  Description : Self-checking bench for mc_control_fsm. A per-instruction
//                cycle schedule model produces the expected control vector
//                for every cycle; literal state traces pin the model.
//                Honours MC_CTRL_HALT_EN for opcode 15 expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [2:0] op;
        logic [1:0] pc_src;
        logic [2:0] state;
        logic       illegal;
        logic       halted;
    } ctl_t;

`ifdef MC_CTRL_HALT_EN
    localparam bit c_HALT_EN = 1'b1;
`else
    localparam bit c_HALT_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
    logic        reg_write, reg_dst, mem_to_reg, illegal, halted;
    logic [1:0]  alu_a_sel, alu_b_sel, pc_src;
    logic [2:0]  alu_op, state;

    ctl_t        w_dut;
    ctl_t        q_exp[$];
    logic        q_mr[$];
    int          trace[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    mc_control_fsm dut (
        .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op(alu_op), .pc_src(pc_src), .state(state),
        .illegal(illegal), .halted(halted)
    );

    assign w_dut = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
                    reg_write, reg_dst, mem_to_reg, alu_a_sel, alu_b_sel, alu_op,
                    pc_src, state, illegal, halted};

    function automatic ctl_t blank(input logic [2:0] st);
        ctl_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    task automatic push(input ctl_t e, input logic mr);
        q_exp.push_back(e);
        q_mr.push_back(mr);
    endtask

    // Expected cycle-by-cycle schedule of one instruction
    task automatic build_instr(input logic [3:0] op, input int fw, input int mw, input int hc);
        ctl_t e;
        bit   bad;
        for (int i = 0; i < fw; i++) begin
            e = blank(3'd0); e.mem_read = 1'b1; e.b_sel = 2'd1;
            push(e, 1'b0);
        end
        e = blank(3'd0); e.mem_read = 1'b1; e.b_sel = 2'd1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(e, 1'b1);
        bad = (op >= 4'd10 && op <= 4'd14) || (op == 4'd15 && !c_HALT_EN);
        e = blank(3'd1); e.b_sel = 2'd2; e.illegal = bad;
        push(e, 1'b0);
        if (bad) return;
        if (op == 4'd15) begin
            for (int i = 0; i < hc; i++) begin
                e = blank(3'd5); e.halted = 1'b1;
                push(e, logic'(i % 2));
            end
            return;
        end
        e = blank(3'd2);
        if (op <= 4'd3) begin
            e.a_sel = 2'd1; e.b_sel = 2'd0; e.op = 3'(op);
        end else if (op == 4'd4 || op == 4'd5 || op == 4'd6) begin
            e.a_sel = 2'd1; e.b_sel = 2'd2; e.op = 3'd0;
        end else if (op == 4'd7) begin
            e.a_sel = 2'd1; e.b_sel = 2'd0; e.op = 3'd1; e.pc_write_cond = 1'b1; e.pc_src = 2'd1;
        end else if (op == 4'd8) begin
            e.pc_write = 1'b1; e.pc_src = 2'd2;
        end else begin
            e.a_sel = 2'd2; e.b_sel = 2'd3; e.op = 3'd4;
        end
        push(e, 1'b0);
        if (op == 4'd7 || op == 4'd8) return;
        if (op == 4'd5 || op == 4'd6) begin
            for (int i = 0; i <= mw; i++) begin
                e = blank(3'd3); e.iord = 1'b1;
                e.mem_read = (op == 4'd5); e.mem_write = (op == 4'd6);
                push(e, (i == mw));
            end
            if (op == 4'd6) return;
        end
        e = blank(3'd4); e.reg_write = 1'b1; e.reg_dst = (op <= 4'd3); e.mem_to_reg = (op == 4'd5);
        push(e, 1'b0);
    endtask

    // Drive each scheduled cycle and compare the DUT against the schedule
    task automatic run_instr(input string name, input logic [3:0] op, input int fw,
                             input int mw, input int hc, input int n_max);
        ctl_t e;
        logic mr;
        int   n;
        q_exp.delete(); q_mr.delete(); trace.delete();
        build_instr(op, fw, mw, hc);
        n = 0;
        while (q_exp.size() > 0 && n < n_max) begin
            e  = q_exp.pop_front();
            mr = q_mr.pop_front();
            @(posedge CLK);
            #1;
            mem_ready = mr;
            opcode    = op;
            @(negedge CLK);
            trace.push_back(int'(state));
            n_checks++;
            if (w_dut !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, n, w_dut, e);
            end
            n++;
        end
    endtask

    task automatic check_trace(input string name, input int exp_tr[$]);
        bit ok;
        ok = (trace.size() == exp_tr.size());
        if (ok) for (int i = 0; i < exp_tr.size(); i++) if (trace[i] != exp_tr[i]) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL trace_%s: got %0d states %p expected %0d states %p",
                     name, trace.size(), trace, exp_tr.size(), exp_tr);
        end
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (w_dut !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h expected 0", name, w_dut);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge CLK);
        RST_N = 1'b0; mem_ready = 1'b1; opcode = 4'd5;
        #1 check_zero(name);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        mem_ready = 1'b0;
        RST_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int halt_tr[$];
        do_reset("reset_outputs_zero");

        run_instr("add", 4'd0, 0, 0, 0, 100);
        check_trace("add", '{0, 1, 2, 4});
        run_instr("sub", 4'd1, 1, 0, 0, 100);
        run_instr("and", 4'd2, 0, 0, 0, 100);
        run_instr("or", 4'd3, 2, 0, 0, 100);
        run_instr("addi", 4'd4, 0, 0, 0, 100);
        run_instr("lw", 4'd5, 0, 2, 0, 100);
        check_trace("lw", '{0, 1, 2, 3, 3, 3, 4});
        run_instr("sw", 4'd6, 0, 1, 0, 100);
        check_trace("sw", '{0, 1, 2, 3, 3});
        zero = 1'b0;
        run_instr("beq_z0", 4'd7, 0, 0, 0, 100);
        check_trace("beq", '{0, 1, 2});
        zero = 1'b1;
        run_instr("beq_z1", 4'd7, 0, 0, 0, 100);
        zero = 1'b0;
        run_instr("j", 4'd8, 0, 0, 0, 100);
        run_instr("lui", 4'd9, 0, 0, 0, 100);
        run_instr("ill12", 4'd12, 0, 0, 0, 100);
        check_trace("ill12", '{0, 1});
        run_instr("add_after_ill", 4'd0, 0, 0, 0, 100);

        run_instr("op15", 4'd15, 0, 0, 20, 100);
        halt_tr.push_back(0);
        halt_tr.push_back(1);
        if (c_HALT_EN) for (int i = 0; i < 20; i++) halt_tr.push_back(5);
        check_trace("op15", halt_tr);
        do_reset("reset_after_op15");
        run_instr("add_after_reset", 4'd0, 0, 0, 0, 100);

        // Reset during an LW memory wait: FETCH, DECODE, EXEC, first MEM wait
        run_instr("lw_abort", 4'd5, 0, 5, 0, 4);
        check_trace("lw_abort", '{0, 1, 2, 3});
        #2 RST_N = 1'b0;
        #1 check_zero("reset_mid_lw_immediate");
        @(posedge CLK);
        @(negedge CLK);
        check_zero("reset_mid_lw_held");
        mem_ready = 1'b0;
        RST_N = 1'b1;
        run_instr("add_after_abort", 4'd0, 0, 0, 0, 100);
        check_trace("add_after_abort", '{0, 1, 2, 4});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
